// File: rtl/chocorrol_emisor.sv
// chocorrol_emisor: issues one validated Chocorrol instruction per command, holds it to settle, samples RESULTADO.
module chocorrol_emisor #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [19:0] NOP_WORD = 20'h00000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_MC,
  input  logic [4:0]  CMD_OP1,
  input  logic [2:0]  CMD_ALUC,
  input  logic [4:0]  CMD_OP2,
  input  logic [4:0]  CMD_MB,
  output logic [19:0] INSTRUCCION,
  input  logic [31:0] RESULTADO,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [31:0] RES_DATO,
  output logic        RES_ERROR,
  output logic [15:0] CUENTA
);
  typedef enum logic [1:0] {IDLE, ESPERA, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  state_t state_q;
  logic [3:0] cnt_q;
  logic [19:0] instr_q;
  logic [31:0] dato_q;
  logic error_q;
  logic [15:0] cuenta_q;
  logic ilegal;
  assign ilegal = (CMD_MC == 2'b11) || (CMD_ALUC == 3'b011) || (CMD_ALUC == 3'b101);
  assign CMD_READY = state_q == IDLE;
  assign RES_VALID = state_q == RESP;
  assign INSTRUCCION = instr_q;
  assign RES_DATO = dato_q;
  assign RES_ERROR = error_q;
  assign CUENTA = cuenta_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      instr_q <= NOP_WORD;
      dato_q <= '0;
      error_q <= 1'b0;
      cuenta_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (CMD_VALID) begin
          if (ilegal) begin
            dato_q <= '0;
            error_q <= 1'b1;
            state_q <= RESP;
          end else begin
            instr_q <= {CMD_MC, CMD_OP1, CMD_ALUC, CMD_OP2, CMD_MB};
            cnt_q <= CNT_INIT;
            cuenta_q <= cuenta_q + 16'd1;
            state_q <= ESPERA;
          end
        end
        // RESULTADO is only trusted once the word has been stable for the whole window
        ESPERA: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          dato_q <= RESULTADO;
          error_q <= 1'b0;
          instr_q <= NOP_WORD;
          state_q <= RESP;
        end
        RESP: if (RES_READY) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
